ps2_key_event_ctrl: RTL and testbench

//  Drains the ps2_keyboard scan-code FIFO with the ready/nextdata_n handshake and

---
 rtl/ps2_key_event_ctrl_if.sv | 22 ++
 rtl/ps2_key_event_ctrl.sv | 148 ++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_event_ctrl_if.sv
// PS/2 keyboard FIFO drain interface.
// The keyboard side drives ready/data/overflow; the controller pops the FIFO.
interface ps2_key_event_ctrl_if;
  logic       kbd_ready;
  logic [7:0] kbd_data;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;

  modport master (
    output kbd_ready,
    output kbd_data,
    output kbd_overflow,
    input  kbd_nextdata_n
  );

  modport slave (
    input  kbd_ready,
    input  kbd_data,
    input  kbd_overflow,
    output kbd_nextdata_n
  );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// Set-2 scan-code decoder: pops the ps2_keyboard FIFO and turns
// make / F0 break / E0 extended sequences into held-key state and pulses.
module ps2_key_event_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ps2_key_event_ctrl_if.slave kbd,
  input  logic             cnt_clr,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_valid,
  output logic             press_pulse,
  output logic             repeat_pulse,
  output logic             release_pulse,
  output logic [CNT_W-1:0] press_cnt,
  output logic             proto_err,
  output logic             ovf_seen
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  logic [1:0] state;
  logic [1:0] state_d;
  logic       pop_n;

  logic       consume;
  logic       is_e0;
  logic       is_f0;
  logic       is_nul;
  logic       do_make;
  logic       do_brk;
  logic       ev_ext;
  logic       err;
  logic       match;

  // A byte is only taken while the pop strobe is idle: max one per 2 clocks.
  assign consume = kbd.kbd_ready & pop_n;
  assign kbd.kbd_nextdata_n = pop_n;

  assign is_e0  = (kbd.kbd_data == 8'hE0);
  assign is_f0  = (kbd.kbd_data == 8'hF0);
  assign is_nul = (kbd.kbd_data == 8'h00) |
                  (kbd.kbd_data == 8'hFF);

  assign match = key_valid &
                 (key_code == kbd.kbd_data) &
                 (key_ext == ev_ext);

  always_comb begin
    state_d = state;
    do_make = 1'b0;
    do_brk  = 1'b0;
    ev_ext  = 1'b0;
    err     = 1'b0;
    if (consume) begin
      case (state)
        S_IDLE: begin
          unique case (1'b1)
            is_e0:   state_d = S_EXT;
            is_f0:   state_d = S_BRK;
            is_nul:  state_d = S_IDLE;
            default: do_make = 1'b1;
          endcase
        end
        S_EXT: begin
          ev_ext = 1'b1;
          unique case (1'b1)
            is_f0:   state_d = S_EXT_BRK;
            is_e0:   state_d = S_EXT;
            is_nul:  state_d = S_IDLE;
            default: begin
              do_make = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          state_d = S_IDLE;
          unique case (1'b1)
            is_e0 | is_f0: err = 1'b1;
            is_nul:        err = 1'b0;
            default:       do_brk = 1'b1;
          endcase
        end
        default: begin
          ev_ext  = 1'b1;
          state_d = S_IDLE;
          unique case (1'b1)
            is_e0 | is_f0: err = 1'b1;
            is_nul:        err = 1'b0;
            default:       do_brk = 1'b1;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pop_n         <= 1'b1;
      key_code      <= 8'h00;
      key_ext       <= 1'b0;
      key_valid     <= 1'b0;
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      press_cnt     <= '0;
      proto_err     <= 1'b0;
      ovf_seen      <= 1'b0;
    end else begin
      state         <= state_d;
      pop_n         <= ~consume;
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      if (kbd.kbd_overflow) ovf_seen <= 1'b1;
      if (err) proto_err <= 1'b1;
      if (do_make) begin
        if (match) begin
          repeat_pulse <= 1'b1;
        end else begin
          key_code    <= kbd.kbd_data;
          key_ext     <= ev_ext;
          key_valid   <= 1'b1;
          press_pulse <= 1'b1;
        end
      end
      // A break for a key other than the held one is dropped silently.
      if (do_brk && match) begin
        key_code      <= 8'h00;
        key_ext       <= 1'b0;
        key_valid     <= 1'b0;
        release_pulse <= 1'b1;
      end
      if (cnt_clr) begin
        press_cnt <= '0;
      end else if (do_make && !match) begin
        press_cnt <= press_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: Set-2 sequences, FIFO
// handshake pacing, counter wrap/clear and sticky flags.
module tb_ps2_key_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_clr;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       press_pulse;
  logic       repeat_pulse;
  logic       release_pulse;
  logic [7:0] press_cnt;
  logic       proto_err;
  logic       ovf_seen;

  int vectors     = 0;
  int miscompares = 0;
  int pops        = 0;
  int dbl         = 0;
  logic prev_low  = 1'b0;

  always #5 clk = ~clk;

  ps2_key_event_ctrl_if bus ();

  ps2_key_event_ctrl #(.CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .kbd           (bus.slave),
    .cnt_clr       (cnt_clr),
    .key_code      (key_code),
    .key_ext       (key_ext),
    .key_valid     (key_valid),
    .press_pulse   (press_pulse),
    .repeat_pulse  (repeat_pulse),
    .release_pulse (release_pulse),
    .press_cnt     (press_cnt),
    .proto_err     (proto_err),
    .ovf_seen      (ovf_seen)
  );

  always @(negedge clk) begin
    if (!rst && bus.kbd_nextdata_n === 1'b0) begin
      pops++;
      if (prev_low) dbl++;
      prev_low = 1'b1;
    end else begin
      prev_low = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    cnt_clr          = 1'b0;
    bus.kbd_ready    = 1'b0;
    bus.kbd_data     = 8'h00;
    bus.kbd_overflow = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic clr);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.kbd_nextdata_n !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("send_wait_ok", 32'(n < 8), 32'd1);
    bus.kbd_ready = 1'b1;
    bus.kbd_data  = b;
    cnt_clr       = clr;
    @(posedge clk);
    #1;
    bus.kbd_ready = 1'b0;
    cnt_clr       = 1'b0;
  endtask

  function automatic logic [2:0] pulses();
    return {press_pulse, repeat_pulse, release_pulse};
  endfunction

  initial begin
    int p0;
    int d0;
    int idx;
    logic [7:0] q [4];

    // Reset state
    do_reset();
    chk("rst_nextdata_n", bus.kbd_nextdata_n, 1);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_valid_ext", {key_valid, key_ext}, 2'b00);
    chk("rst_pulses", pulses(), 3'b000);
    chk("rst_cnt", press_cnt, 8'h00);
    chk("rst_sticky", {proto_err, ovf_seen}, 2'b00);
    release_reset();

    // T1: 1C, F0, 1C
    p0 = pops;
    send(8'h1C, 1'b0);
    chk("t1_pop_low", bus.kbd_nextdata_n, 0);
    chk("t1_press", pulses(), 3'b100);
    chk("t1_code", key_code, 8'h1C);
    chk("t1_valid", key_valid, 1);
    @(posedge clk); #1;
    chk("t1_pulse_1cyc", pulses(), 3'b000);
    chk("t1_pop_back", bus.kbd_nextdata_n, 1);
    send(8'hF0, 1'b0);
    chk("t1_f0_nopulse", pulses(), 3'b000);
    send(8'h1C, 1'b0);
    chk("t1_release", pulses(), 3'b001);
    chk("t1_valid0", key_valid, 0);
    chk("t1_code0", key_code, 8'h00);
    chk("t1_cnt", press_cnt, 8'd1);
    @(posedge clk); #1;
    chk("t1_pops", pops - p0, 3);

    // 00/FF ignored in IDLE; non-matching break ignored
    send(8'h00, 1'b0);
    chk("nul_ignored", pulses(), 3'b000);
    send(8'h2B, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h3C, 1'b0);
    chk("nomatch_brk", {pulses(), key_valid}, 4'b0001);
    chk("nomatch_code", key_code, 8'h2B);

    // T2: extended press/release, then 1C overrides, stray E0 F0 75
    do_reset();
    release_reset();
    send(8'hE0, 1'b0);
    chk("t2_e0_nopulse", pulses(), 3'b000);
    send(8'h75, 1'b0);
    chk("t2_press", pulses(), 3'b100);
    chk("t2_code_ext", {key_ext, key_code}, 9'h175);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    chk("t2_release", pulses(), 3'b001);
    chk("t2_valid0", {key_valid, key_ext}, 2'b00);
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0);
    send(8'h1C, 1'b0);
    chk("t2_1c_press", pulses(), 3'b100);
    chk("t2_1c_code", {key_ext, key_code}, 9'h01C);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    chk("t2_stray_brk", {pulses(), key_valid}, 4'b0001);
    chk("t2_held_1c", key_code, 8'h1C);
    chk("t2_cnt", press_cnt, 8'd3);
    // Same code without E0 is a different key than E0-prefixed
    send(8'hE0, 1'b0);
    send(8'h1C, 1'b0);
    chk("t2_ext_newkey", pulses(), 3'b100);

    // T3: typematic repeat
    do_reset();
    release_reset();
    send(8'h15, 1'b0);
    chk("t3_b1", pulses(), 3'b100);
    send(8'h15, 1'b0);
    chk("t3_b2", pulses(), 3'b010);
    send(8'h15, 1'b0);
    chk("t3_b3", pulses(), 3'b010);
    send(8'hF0, 1'b0);
    chk("t3_b4", pulses(), 3'b000);
    send(8'h15, 1'b0);
    chk("t3_b5", pulses(), 3'b001);
    chk("t3_cnt", press_cnt, 8'd1);

    // T4: ready held high with 4 queued bytes
    do_reset();
    release_reset();
    q = '{8'h1A, 8'h1A, 8'hF0, 8'h1A};
    p0 = pops;
    d0 = dbl;
    idx = 0;
    bus.kbd_ready = 1'b1;
    bus.kbd_data  = q[0];
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk);
      if (bus.kbd_nextdata_n === 1'b0) begin
        idx++;
        if (idx < 4) bus.kbd_data = q[idx];
        else bus.kbd_ready = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    chk("t4_drained", idx, 4);
    chk("t4_pops", pops - p0, 4);
    chk("t4_no_dbl_low", dbl - d0, 0);
    chk("t4_cnt", press_cnt, 8'd1);
    chk("t4_released", key_valid, 0);

    // T5: F0 E0 is illegal; following byte is a plain make
    do_reset();
    release_reset();
    send(8'hF0, 1'b0);
    chk("t5_no_err_yet", proto_err, 0);
    send(8'hE0, 1'b0);
    chk("t5_err", proto_err, 1);
    send(8'h23, 1'b0);
    chk("t5_press", pulses(), 3'b100);
    chk("t5_code", {key_ext, key_code}, 9'h023);
    chk("t5_err_sticky", proto_err, 1);

    // T6: counter wrap, clear priority, overflow sticky
    do_reset();
    release_reset();
    for (int i = 0; i < 255; i++) begin
      send((i % 2) ? 8'h16 : 8'h1E, 1'b0);
    end
    chk("t6_cnt_max", press_cnt, 8'hFF);
    send(8'h26, 1'b0);
    chk("t6_wrap", press_cnt, 8'h00);
    chk("t6_wrap_press", pulses(), 3'b100);
    send(8'h2E, 1'b1);
    chk("t6_clr_wins", press_cnt, 8'h00);
    chk("t6_clr_press", pulses(), 3'b100);
    chk("t6_clr_code", key_code, 8'h2E);
    send(8'h36, 1'b0);
    chk("t6_after_clr", press_cnt, 8'h01);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("t6_clr_alone", press_cnt, 8'h00);
    chk("t6_no_ovf_yet", ovf_seen, 0);
    @(negedge clk);
    bus.kbd_overflow = 1'b1;
    @(negedge clk);
    bus.kbd_overflow = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_ovf_sticky", ovf_seen, 1);
    chk("t6_proto_clean", proto_err, 0);
    do_reset();
    chk("t6_ovf_rst", ovf_seen, 0);
    release_reset();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
